// File: rtl/uart_pkg.sv
// uart_pkg: types and default parameters shared by the UART transmitter and receiver.
//   tx_state_t      : transmitter FSM state encoding
//   DBIT/DB_TICK/SB_TICK/M : default frame and baud timing parameters
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DBIT    = 8;   // data bits per frame
  localparam int DB_TICK = 16;  // baud ticks per start/data bit
  localparam int SB_TICK = 16;  // baud ticks per stop bit (16/24/32 = 1/1.5/2)
  localparam int M       = 8;   // clk cycles per baud tick, must be >= 2

endpackage

// File: rtl/uart_tx_baud_gen.sv
// baud_gen: free-running oversampling tick generator.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   tick out one-clk pulse every M clk cycles (when the counter reaches M-1)
module baud_gen #(
  parameter int M = uart_pkg::M
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter (start bit, DBIT data bits LSB first, stop bit)
// with an integrated baud tick generator.
//   clk          in  system clock
//   rst          in  asynchronous active-high reset
//   tx_start     in  one-cycle send request, only honoured in IDLE
//   din          in  byte to send, captured when tx_start is accepted
//   tx           out serial line, idle high, registered
//   tx_done_tick out one-clk pulse in the first IDLE cycle after the stop bit
//   tx_busy      out high whenever the FSM is not in IDLE
//   tick         out baud tick, exported for sharing with the receiver
//
// state | meaning
// IDLE  | line high, waiting for tx_start
// START | driving start bit (0) for DB_TICK ticks
// DATA  | driving b[0], shifting right every DB_TICK ticks, DBIT bits total
// STOP  | driving stop bit (1) for SB_TICK ticks
module uart_tx #(
  parameter int DBIT    = uart_pkg::DBIT,
  parameter int DB_TICK = uart_pkg::DB_TICK,
  parameter int SB_TICK = uart_pkg::SB_TICK,
  parameter int M       = uart_pkg::M
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            tx_busy,
  output logic            tick
);

  import uart_pkg::*;

  localparam int S_MAX = (DB_TICK > SB_TICK) ? DB_TICK : SB_TICK;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_DB_LAST = S_W'(DB_TICK - 1);
  localparam logic [S_W-1:0] S_SB_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST    = N_W'(DBIT - 1);

  tx_state_t       state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  baud_gen #(.M(M)) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // tx_d decodes the current state, so the line lags the state by one clk.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          if (s_q == S_DB_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (tick) begin
          if (s_q == S_DB_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (s_q == S_SB_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a cycle-level frame timing model.
module tb_uart_tx;

  localparam int DBIT    = 8;
  localparam int DB_TICK = 16;
  localparam int SB_TICK = 16;
  localparam int M       = 8;
  localparam int BIT_CLK = DB_TICK * M;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] din;
  logic       tx;
  logic       tx_done_tick;
  logic       tx_busy;
  logic       tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .DBIT    (DBIT),
    .DB_TICK (DB_TICK),
    .SB_TICK (SB_TICK),
    .M       (M)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx),
    .tx_done_tick (tx_done_tick),
    .tx_busy      (tx_busy),
    .tick         (tick)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Frame model. Cycle c = number of rising edges since reset release; the
  // baud counter reads c mod M, so tick is high in cycles with c mod M = M-1.
  // A frame accepted in cycle a: line low from a+2, start bit ends one clk
  // after the DB_TICK-th tick seen from cycle a+1 onward, every data bit is
  // BIT_CLK long, done pulses SB_TICK*M-1 cycles after the stop bit begins.
  bit         fv;
  int         fa;
  logic [7:0] fd;
  int         cyc;

  function automatic int data_start(input int a);
    return ((a + 1 + M) / M) * M - 1 + (DB_TICK - 1) * M + 2;
  endfunction

  function automatic int stop_start(input int a);
    return data_start(a) + DBIT * BIT_CLK;
  endfunction

  function automatic int done_cyc(input int a);
    return stop_start(a) - 1 + SB_TICK * M;
  endfunction

  function automatic logic m_tx(input int c);
    int k;
    if (!fv || c < fa + 2 || c >= stop_start(fa)) return 1'b1;
    if (c < data_start(fa)) return 1'b0;
    k = (c - data_start(fa)) / BIT_CLK;
    return fd[k[2:0]];
  endfunction

  function automatic logic m_busy(input int c);
    return fv && (c >= fa + 1) && (c < done_cyc(fa));
  endfunction

  function automatic logic m_done(input int c);
    return fv && (c == done_cyc(fa));
  endfunction

  function automatic logic m_tick(input int c);
    return (c % M) == (M - 1);
  endfunction

  // Per-cycle compare against the model.
  initial begin
    fv  = 1'b0;
    fa  = 0;
    fd  = 8'h00;
    cyc = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        cyc = 0;
        fv  = 1'b0;
      end else begin
        if (tx_start && !m_busy(cyc)) begin
          fv = 1'b1;
          fa = cyc;
          fd = din;
        end
        cyc++;
      end
      #1;
      if (rst) begin
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_busy", tx_busy, 1'b0);
        chk1("rst_done", tx_done_tick, 1'b0);
        chk1("rst_tick", tick, 1'b0);
      end else begin
        chk1("model_tx", tx, m_tx(cyc));
        chk1("model_busy", tx_busy, m_busy(cyc));
        chk1("model_done", tx_done_tick, m_done(cyc));
        chk1("model_tick", tick, m_tick(cyc));
      end
    end
  end

  // Waits for the start bit, samples the line mid-bit against a hand-written
  // pattern (pat[i] = i-th line bit), and returns on the negedge of the done pulse.
  task automatic sample_frame(input string nm, input logic [9:0] pat, output int w);
    int o, k, slen, doff;
    bit in_start, got_done;
    w = 0;
    while (tx !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      chk1({nm, "_start_seen"}, tx, 1'b0);
      return;
    end
    o = 0; k = 0; slen = -1; doff = -1;
    in_start = 1'b1;
    got_done = 1'b0;
    while (!got_done && o <= 1400) begin
      if (in_start && tx === 1'b1) begin
        in_start = 1'b0;
        slen = o;
      end
      if (k < 10 && o == 60 + k * BIT_CLK) begin
        chk1($sformatf("%s_bit%0d", nm, k), tx, pat[k[3:0]]);
        k++;
      end
      if (tx_done_tick === 1'b1) begin
        got_done = 1'b1;
        doff = o;
      end else begin
        @(negedge clk);
        o++;
      end
    end
    chki({nm, "_bits_sampled"}, k, 10);
    chk_range({nm, "_done_offset"}, doff, 1272, 1279);
    if (pat[1]) begin
      chk_range({nm, "_start_len"}, slen, 121, 128);
      chki({nm, "_start_to_done"}, doff - slen, 1151);
    end
  endtask

  initial begin
    int w, n;
    rst = 1'b1;
    tx_start = 1'b0;
    din = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    n = 0;
    repeat (64) begin
      @(negedge clk);
      if (tick) n++;
    end
    chki("tick_count_64clk", n, 8);

    // 0x55 with an ignored 0xFF request in the middle of the frame
    @(negedge clk); din = 8'h55; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0; din = 8'h00;
    fork
      sample_frame("f55", 10'b1010101010, w);
      begin
        repeat (400) @(negedge clk);
        din = 8'hFF; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    chki("f55_start_delay", w, 1);
    repeat (20) @(negedge clk);
    chk1("f55_idle_after", tx_busy, 1'b0);

    // 0xA3 then 0x0F requested on the done cycle
    @(negedge clk); din = 8'hA3; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    sample_frame("fa3", 10'b1101000110, w);
    chki("fa3_start_delay", w, 1);
    chk1("fa3_done_high", tx_done_tick, 1'b1);
    chk1("fa3_busy_at_done", tx_busy, 1'b0);
    din = 8'h0F; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    sample_frame("f0f", 10'b1000011110, w);
    chki("b2b_gap", w, 1);
    repeat (20) @(negedge clk);

    // reset during data bit 3
    @(negedge clk); din = 8'h55; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk1("rstmid_frame_started", tx, 1'b0);
    repeat (4 * BIT_CLK + 60) @(negedge clk);
    chk1("rstmid_pre_bit3", tx, 1'b0);
    rst = 1'b1;
    #1;
    chk1("rstmid_tx", tx, 1'b1);
    chk1("rstmid_busy", tx_busy, 1'b0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done_tick) n++;
    end
    rst = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (tx_done_tick) n++;
    end
    chki("rstmid_no_done", n, 0);

    @(negedge clk); din = 8'h55; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    sample_frame("f55_post_rst", 10'b1010101010, w);
    chki("f55_post_rst_start_delay", w, 1);
    repeat (50) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter with an integrated baud-tick generator. It accepts a parallel byte on a one-cycle start strobe and shifts it out LSB-first as a standard 8N1-style frame: start bit, data bits, then stop bit. The bit timing uses an oversampled tick of DB_TICK ticks per bit. The block sits between the host logic and the serial pin, and pairs with the receiver, which uses the same tick scheme.

## Interface
- DBIT, 8: number of data bits per frame.
- DB_TICK, 16: baud ticks per start bit and per data bit.
- SB_TICK, 16: baud ticks per stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- M, 8: clk cycles per baud tick; must be ≥ 2.

- Clocking and reset: one clock; reset is asynchronous and active-high.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous reset.
- tx_start  in  1  one-cycle request; sampled only in IDLE.
- din  in  DBIT  data to send; captured on the accepted tx_start cycle.
- tx  out  1  serial line; idle high; registered.
- tx_done_tick  out  1  one-cycle pulse at end of stop bit.
- tx_busy  out  1  high whenever state ≠ IDLE.
- tick  out  1  baud tick, for observation and for sharing with the receiver.

## Operation
- Baud generator:
  - Free-running counter 0..M-1, width $clog2(M).
  - tick = 1 for exactly one clk when the counter = M-1, then it wraps to 0.
  - Runs continuously and independently of the FSM.
- FSM states: IDLE, START, DATA, STOP. Registers:
  - s: tick counter, width ≥ $clog2(max(DB_TICK, SB_TICK)).
  - n: bit index, width $clog2(DBIT).
  - b: shift register, DBIT wide.
  - tx_reg.
- IDLE:
  - tx_next = 1.
  - If tx_start: b ← din, s ← 0, go to START. Otherwise hold.
- START: tx_next = 0. On each tick:
  - If s = DB_TICK-1: s ← 0, n ← 0, go to DATA.
  - Otherwise s ← s+1.
- DATA: tx_next = b[0]. On each tick:
  - If s = DB_TICK-1: s ← 0, b ← b >> 1.
    - If n = DBIT-1, go to STOP.
    - Otherwise n ← n+1.
  - Otherwise s ← s+1.
- STOP: tx_next = 1. On each tick:
  - If s = SB_TICK-1: go to IDLE and assert tx_done_tick next cycle.
  - Otherwise s ← s+1.
- tx_start outside IDLE is ignored. No queuing; din changes mid-frame have no effect.
- tx_start in the same cycle that tx_done_tick fires: accepted only if the FSM is already in IDLE in that cycle, which it is.
- Arithmetic: all counters are unsigned, with no overflow paths. Compare for equality at terminal counts only.

## Timing
- Reset values:
  - state IDLE, s = 0, n = 0, b = 0, baud counter = 0.
  - tx = 1, tx_done_tick = 0, tx_busy = 0, tick = 0.
- tx is registered: it follows the state decode by one clk. Accepting tx_start at edge k drives tx = 0 after edge k+1.
- Start bit lasts DB_TICK ticks, counted from the first tick after acceptance. Its length is (DB_TICK-1)·M + 1 to DB_TICK·M clk, depending on tick phase.
- Each data bit lasts exactly DB_TICK·M clk; the stop bit lasts SB_TICK·M clk.
- With defaults, each bit is 128 clk and a frame is ≈1280 clk.
- tx_done_tick is registered: high for exactly one clk, in the first cycle the state is IDLE after STOP. tx_busy deasserts in the same cycle.
- Back-to-back: tx_start asserted on the tx_done_tick cycle starts a new frame with no extra idle bit beyond the stop bit.
- Reset mid-frame: immediately IDLE, tx = 1, no tx_done_tick, and the baud counter restarts at 0.

## Structure
- Package uart_pkg:
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}.
  - Default localparams DBIT, DB_TICK, SB_TICK, M, shared with the receiver.
- Sub-module baud_gen (parameter M; ports clk, rst, tick) is instantiated once inside uart_tx. The rest is a single FSM plus datapath in uart_tx.

## Test plan
- Reset: hold rst 5 cycles → tx = 1, tx_busy = 0, tx_done_tick = 0, tick = 0. After release, tick pulses every 8 clk, one cycle wide.
- Send 0x55 (M = 8) → line sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop). Each data bit lasts 128 clk. Exactly one tx_done_tick pulse at frame end.
- Wait 20 clk, send 0xA3 → 0, 1,1,0,0,0,1,0,1, 1. tx_done_tick pulses once, and tx_busy falls in that cycle.
- Pulse tx_start with din = 0xFF mid-frame during 0x55 → ignored. The frame stays 0x55 and no second frame follows.
- Assert tx_start with 0x0F on the tx_done_tick cycle → the new start bit follows the stop bit with no gap. Bits 1,1,1,1,0,0,0,0.
- Assert rst during DATA bit 3 → tx = 1 within one clk, no tx_done_tick. A subsequent send of 0x55 transmits correctly.
